// File: rtl/q_align_stream.sv
// Multi-lane fixed-point Q-format realigner with selectable rounding, per-lane saturation and a
// sticky saturation event counter, behind a single-register valid/ready stage.
`ifndef Q_WIDTH
`define Q_WIDTH(i, f) (1 + (i) + (f))
`endif

module q_align_stream #(
    parameter int IN_I  = 4,
    parameter int IN_F  = 8,
    parameter int OUT_I = 2,
    parameter int OUT_F = 4,
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                                      clock,
    input  logic                                      reset_n,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [LANES*`Q_WIDTH(IN_I, IN_F)-1:0]     in_data,
    input  logic [1:0]                                round_mode,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [LANES*`Q_WIDTH(OUT_I, OUT_F)-1:0]   out_data,
    output logic [LANES-1:0]                          out_sat,
    output logic [CNT_W-1:0]                          sat_cnt,
    input  logic                                      sat_cnt_clr
);

    localparam int W_IN  = `Q_WIDTH(IN_I, IN_F);
    localparam int W_OUT = `Q_WIDTH(OUT_I, OUT_F);
    localparam int SH_L  = (OUT_F >= IN_F) ? OUT_F - IN_F : 0;
    localparam int SH_R  = (OUT_F < IN_F) ? IN_F - OUT_F : 0;
    // Wide enough for the left shift, a rounding carry and any output range.
    localparam int WC    = W_IN + SH_L + W_OUT + 2;

    localparam logic signed [WC-1:0] MAXV = {{(WC-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
    localparam logic signed [WC-1:0] MINV = {{(WC-W_OUT+1){1'b1}}, {(W_OUT-1){1'b0}}};

    logic [LANES*W_OUT-1:0] lane_val;
    logic [LANES-1:0]       lane_sat;
    logic                   accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [WC-1:0] x;
        logic signed [WC-1:0] r;

        assign x = WC'($signed(in_data[k*W_IN +: W_IN]));

        if (SH_R == 0) begin : g_up
            assign r = x <<< SH_L;
        end else begin : g_dn
            localparam logic [SH_R-1:0] HALF = SH_R'(1) << (SH_R - 1);
            logic signed [WC-1:0] q;
            logic [SH_R-1:0]      rem;
            logic                 inc;

            assign q   = x >>> SH_R;
            assign rem = x[SH_R-1:0];

            always_comb begin
                inc = 1'b0;
                case (round_mode)
                    2'b01:   inc = rem[SH_R-1];
                    2'b10:   inc = (rem > HALF) || ((rem == HALF) && q[0]);
                    default: inc = 1'b0;
                endcase
            end

            assign r = q + {{(WC-1){1'b0}}, inc};
        end

        assign lane_sat[k] = (r > MAXV) || (r < MINV);
        assign lane_val[k*W_OUT +: W_OUT] = (r > MAXV) ? MAXV[W_OUT-1:0] :
                                            (r < MINV) ? MINV[W_OUT-1:0] : r[W_OUT-1:0];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= lane_val;
            out_sat   <= lane_sat;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sat_cnt <= '0;
        end else if (sat_cnt_clr) begin
            sat_cnt <= '0;
        end else if (accept && (|lane_sat) && (sat_cnt != {CNT_W{1'b1}})) begin
            sat_cnt <= sat_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_q_align_stream.sv
// Directed self-checking bench for q_align_stream at default parameters.
module tb_q_align_stream;

    localparam int LANES = 4;
    localparam int CNT_W = 16;
    localparam int W_IN  = 13;
    localparam int W_OUT = 7;

    logic                     clock = 1'b0;
    logic                     reset_n = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [LANES*W_IN-1:0]    in_data = '0;
    logic [1:0]               round_mode = 2'b00;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic [LANES*W_OUT-1:0]   out_data;
    logic [LANES-1:0]         out_sat;
    logic [CNT_W-1:0]         sat_cnt;
    logic                     sat_cnt_clr = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    q_align_stream dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .round_mode  (round_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_sat     (out_sat),
        .sat_cnt     (sat_cnt),
        .sat_cnt_clr (sat_cnt_clr)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint lane(input int k);
        return longint'($signed(out_data[k*W_OUT +: W_OUT]));
    endfunction

    function automatic logic [W_IN-1:0] raw(input int v);
        int t;
        t = v;
        return t[W_IN-1:0];
    endfunction

    // One accepted beat with out_ready high; returns one cycle after the accept edge.
    task automatic beat(input int l0, input int l1, input int l2, input int l3,
                        input logic [1:0] mode);
        @(negedge clock);
        in_valid   = 1'b1;
        in_data    = {raw(l3), raw(l2), raw(l1), raw(l0)};
        round_mode = mode;
        out_ready  = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e_pos[4];
        int e_neg[4];
        int e_tie[4];
        int exp_q[$];
        int sent;
        int got;

        // Reset state
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_sat_cnt", sat_cnt, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clock);
        reset_n = 1'b1;

        // Rounding modes: 24.5, -24.5, -25.5 (mode 3 behaves as TRUNC)
        e_pos = '{24, 25, 24, 24};
        e_neg = '{-25, -24, -24, -25};
        e_tie = '{-26, -25, -26, -26};
        for (int m = 0; m < 4; m++) begin
            beat(392, -392, 0, -408, 2'(m));
            check($sformatf("rnd_valid_m%0d", m), out_valid, 1);
            check($sformatf("rnd_pos_m%0d", m), lane(0), e_pos[m]);
            check($sformatf("rnd_neg_m%0d", m), lane(1), e_neg[m]);
            check($sformatf("rnd_zero_m%0d", m), lane(2), 0);
            check($sformatf("rnd_tie_m%0d", m), lane(3), e_tie[m]);
            check($sformatf("rnd_sat_m%0d", m), out_sat, 0);
        end
        check("rnd_sat_cnt", sat_cnt, 0);

        // Saturation both directions
        beat(0, 1280, -1280, 0, 2'b00);
        check("sat_l1", lane(1), 63);
        check("sat_l2", lane(2), -64);
        check("sat_flags", out_sat, 4'b0110);
        check("sat_cnt1", sat_cnt, 1);
        beat(-4096, 0, 0, 4095, 2'b10);
        check("sat_minneg", lane(0), -64);
        check("sat_maxpos", lane(3), 63);
        check("sat_flags2", out_sat, 4'b1001);
        check("sat_cnt2", sat_cnt, 2);

        // Rounding carry into saturation
        beat(1016, 0, 0, 0, 2'b01);
        check("carry_rhu", lane(0), 63);
        check("carry_rhu_sat", out_sat, 4'b0001);
        check("carry_rhu_cnt", sat_cnt, 3);
        beat(1016, 0, 0, 0, 2'b10);
        check("carry_rne", lane(0), 63);
        check("carry_rne_sat", out_sat, 4'b0001);
        check("carry_rne_cnt", sat_cnt, 4);
        beat(1016, 0, 0, 0, 2'b00);
        check("carry_trunc", lane(0), 63);
        check("carry_trunc_sat", out_sat, 0);
        check("carry_trunc_cnt", sat_cnt, 4);
        @(negedge clock);
        check("drain_valid", out_valid, 0);

        // Backpressure stall
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        round_mode = 2'b00;
        in_data    = {raw(0), raw(0), raw(0), raw(80)};
        @(negedge clock);
        check("stall_valid", out_valid, 1);
        check("stall_ready", in_ready, 0);
        check("stall_a", lane(0), 5);
        in_data = {raw(0), raw(0), raw(0), raw(112)};
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check($sformatf("stall_ready_%0d", i), in_ready, 0);
            check($sformatf("stall_hold_%0d", i), lane(0), 5);
        end
        out_ready = 1'b1;
        #1;
        check("release_ready", in_ready, 1);
        @(negedge clock);
        check("release_b_valid", out_valid, 1);
        check("release_b", lane(0), 7);
        in_valid = 1'b0;
        @(negedge clock);
        check("release_drain", out_valid, 0);

        // Back-to-back stream with random backpressure after a full-rate phase
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 400 && got < 40; cyc++) begin
            @(negedge clock);
            out_ready = (cyc < 20) ? 1'b1 : 1'($urandom_range(0, 1));
            in_valid  = (sent < 40);
            in_data   = {raw(0), raw(0), raw(0), raw(sent * 16)};
            #1;
            if (cyc > 0 && cyc < 20) check("tput_valid", out_valid, 1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("order_extra", 1, 0);
                else check("order", lane(0), exp_q.pop_front());
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(sent);
                sent++;
            end
        end
        in_valid = 1'b0;
        check("stream_count", got, 40);
        out_ready = 1'b1;
        @(negedge clock);

        // Asynchronous reset mid-stall
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = {raw(0), raw(0), raw(1280), raw(0)};
        @(negedge clock);
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_sat", out_sat, 4'b0010);
        check("pre_rst_cnt", sat_cnt, 5);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_data", out_data, 0);
        check("arst_sat", out_sat, 0);
        check("arst_cnt", sat_cnt, 0);
        check("arst_ready", in_ready, 1);
        @(negedge clock);
        reset_n = 1'b1;

        // Clear wins over a simultaneous saturating accept
        beat(0, 1280, 0, 0, 2'b00);
        check("clr_pre_cnt", sat_cnt, 1);
        @(negedge clock);
        in_valid    = 1'b1;
        sat_cnt_clr = 1'b1;
        @(negedge clock);
        in_valid    = 1'b0;
        sat_cnt_clr = 1'b0;
        check("clr_cnt", sat_cnt, 0);
        check("clr_sat", out_sat, 4'b0010);
        beat(0, 1280, 0, 0, 2'b00);
        check("clr_post_cnt", sat_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/q_align_stream.md
Q_ALIGN_STREAM -- requirements
Module: q_align_stream

Interface
REQ-001 SHALL have parameter IN_I, default 4: integer bits of the input Q format.
REQ-002 SHALL have parameter IN_F, default 8: fractional bits of the input Q format.
REQ-003 SHALL have parameter OUT_I, default 2: integer bits of the output Q format.
REQ-004 SHALL have parameter OUT_F, default 4: fractional bits of the output Q format.
REQ-005 SHALL have parameter LANES, default 4: number of independent parallel lanes.
REQ-006 SHALL have parameter CNT_W, default 16: width of the saturation event counter.
REQ-007 SHALL derive W_IN = `Q_WIDTH(IN_I,IN_F) = 1+IN_I+IN_F and W_OUT = `Q_WIDTH(OUT_I,OUT_F) = 1+OUT_I+OUT_F; values are two's complement.
REQ-008 SHALL have port clock, input, 1 bit: single clock; all state updates on the rising edge.
REQ-009 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-010 SHALL have port in_valid, input, 1 bit: the input beat is valid.
REQ-011 SHALL have port in_ready, output, 1 bit: the block can accept a beat.
REQ-012 SHALL have port in_data, input, LANES*W_IN bits: lane k occupies bits [k*W_IN +: W_IN].
REQ-013 SHALL have port round_mode, input, 2 bits: 00 TRUNC, 01 RHU, 10 RNE, 11 treated as TRUNC; sampled per accepted beat.
REQ-014 SHALL have port out_valid, output, 1 bit: the output beat is valid.
REQ-015 SHALL have port out_ready, input, 1 bit: downstream accepts the output beat.
REQ-016 SHALL have port out_data, output, LANES*W_OUT bits: lane k occupies bits [k*W_OUT +: W_OUT].
REQ-017 SHALL have port out_sat, output, LANES bits: per-lane flag, set when that lane saturated.
REQ-018 SHALL have port sat_cnt, output, CNT_W bits: count of accepted beats with any lane saturated.
REQ-019 SHALL have port sat_cnt_clr, input, 1 bit: synchronous clear of sat_cnt.

Function
REQ-020 SHALL accept a beat when in_valid && in_ready and emit a beat when out_valid && out_ready.
REQ-021 SHALL drive in_ready = !out_valid || out_ready, a combinational single-register pipeline giving full throughput.
REQ-022 SHALL present an accepted beat on out_data/out_sat in the next cycle: latency 1, out_valid set.
REQ-023 SHALL clear out_valid on an out_ready cycle with no new accept, and hold out_data/out_sat stable while out_valid && !out_ready.
REQ-024 SHALL, when OUT_F >= IN_F, left-shift each lane by OUT_F-IN_F, exact with no rounding.
REQ-025 SHALL, when OUT_F < IN_F, discard D = IN_F-OUT_F LSBs using the sampled round mode.
- TRUNC: arithmetic floor toward -inf.
- RHU: add 2^(D-1), then floor.
- RNE: round half to even; ties go to the even result LSB.
REQ-026 SHALL compute rounding with at least one guard integer bit, so a rounding carry is never lost before saturation.
REQ-027 SHALL saturate each lane after rounding to [-2^(W_OUT-1), 2^(W_OUT-1)-1] raw and set out_sat[k] when clamping occurred; this applies for any IN_I/OUT_I relation.
REQ-028 SHALL process lanes independently; the most negative input SHALL NOT overflow internally.
REQ-029 SHALL increment sat_cnt by 1 per accepted beat with any lane saturating, stick at 2^CNT_W-1, and let sat_cnt_clr take priority over the increment in the same cycle.

Reset
REQ-030 SHALL, on reset_n low, immediately force out_valid=0, out_data=0, out_sat=0 and sat_cnt=0, regardless of clock.
REQ-031 SHALL drop a beat in flight when reset is asserted mid-transfer; in_ready=1 after reset.

Verification
REQ-032 SHALL be verified with defaults, lane0 in 1.53125 (raw 392), one run per mode: TRUNC -> raw 24, RHU -> 25, RNE -> 24, out_sat=0, one cycle after accept.
REQ-033 SHALL be verified with lane1 in +5.0 (raw 1280) and lane2 in -5.0 (raw -1280): out raw 63 and -64, out_sat=0b0110, sat_cnt +1.
REQ-034 SHALL be verified with in 3.96875 (raw 1016), RHU and RNE: 63.5 rounds to 64 and saturates to 63 with out_sat set; TRUNC gives 63 with no saturation.
REQ-035 SHALL be verified by holding out_ready=0 for 5 cycles with in_valid=1: in_ready=0 after the first accept, out_data stable, and no beat lost or duplicated after release.
REQ-036 SHALL be verified with back-to-back beats and random out_ready: 1 beat/cycle when out_ready=1, and output order matches input order.
REQ-037 SHALL be verified with reset_n pulsed low mid-stall and sat_cnt_clr asserted together with a saturating accept: all outputs 0 asynchronously, and sat_cnt=0 after the clear.
